// File: rtl/conv_coder.sv
// Serial rate-1/2 feed-forward convolutional encoder.
// Each input bit is taken on a phase-0 edge; its G0 bit and then its G1 bit are shifted out on y.
module conv_coder #(
    parameter int unsigned    K  = 3,
    parameter logic [K-1:0]   G0 = 3'b111,
    parameter logic [K-1:0]   G1 = 3'b101
) (
    input  logic clk,
    input  logic reset,
    input  logic x,
    output logic y
);

    logic [K-2:0] sr_q, sr_d;
    logic [K-1:0] tap_vec;
    logic         phase_q;
    logic         g1_hold_q;
    logic         y_q;
    logic         g0_bit, g1_bit;

    // Current input sits above the history so generator MSBs tap it directly.
    always_comb begin
        tap_vec = {x, sr_q};
        g0_bit  = ^(tap_vec & G0);
        g1_bit  = ^(tap_vec & G1);
        sr_d    = '0;
        sr_d[K-2] = x;
        for (int i = 0; i < int'(K) - 2; i++) begin
            sr_d[i] = sr_q[i+1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sr_q      <= '0;
            phase_q   <= 1'b0;
            g1_hold_q <= 1'b0;
            y_q       <= 1'b0;
        end else if (!phase_q) begin
            y_q       <= g0_bit;
            g1_hold_q <= g1_bit;
            sr_q      <= sr_d;
            phase_q   <= 1'b1;
        end else begin
            y_q       <= g1_hold_q;
            phase_q   <= 1'b0;
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_conv_coder.sv
// Scoreboard bench for conv_coder: stimulus queues hand-computed coded bits,
// a negedge monitor pops and compares them against y.
module tb_conv_coder;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic x = 1'b0;
    logic y;

    conv_coder dut (
        .clk   (clk),
        .reset (reset),
        .x     (x),
        .y     (y)
    );

    always #5 clk = ~clk;

    bit    q[$];
    bit    armed = 1'b0;
    int    total = 0;
    int    bad = 0;
    string tname = "init";

    // Expected bits are pushed one negedge ahead of the edge that produces them.
    always @(posedge clk) armed <= (q.size() != 0);

    always @(negedge clk) begin
        bit e;
        if (armed && q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (y !== e) begin
                bad++;
                $display("FAIL %s: y=%0b expected=%0b at %0t", tname, y, e, $time);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        x = 1'($urandom);
        @(negedge clk);
        q.push_back(1'b0);
    endtask

    task automatic send(input bit b, input bit e0, input bit e1, input bit glitch);
        @(negedge clk);
        reset = 1'b1;
        x = b;
        q.push_back(e0);
        q.push_back(e1);
        @(negedge clk);
        if (glitch) x = ~b;
    endtask

    task automatic run_seq(input string name, input int n, input logic [15:0] bits,
                           input logic [31:0] exp, input bit glitch);
        tname = name;
        do_reset();
        for (int i = 0; i < n; i++) begin
            send(bits[n-1-i], exp[2*n-1-2*i], exp[2*n-2-2*i], glitch);
        end
    endtask

    initial begin
        int waited;
        repeat (2) @(negedge clk);

        run_seq("seq1001100", 7, 16'b1001100, 32'b11101111010111, 1'b0);
        run_seq("allzero", 8, 16'b0, 32'b0, 1'b0);
        run_seq("impulse", 4, 16'b1000, 32'b11101100, 1'b0);
        run_seq("glitch", 7, 16'b1001100, 32'b11101111010111, 1'b1);

        // Reset right after a phase-0 sample of 1: G1 is dropped, state cleared.
        tname = "reset_mid";
        do_reset();
        @(negedge clk);
        reset = 1'b1;
        x = 1'b1;
        q.push_back(1'b1);
        q.push_back(1'b0);
        @(negedge clk);
        reset = 1'b0;
        x = 1'($urandom);
        tname = "after_reset";
        send(1'b1, 1'b1, 1'b1, 1'b0);
        send(1'b0, 1'b1, 1'b0, 1'b0);

        waited = 0;
        while (q.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d required=0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_coder.md
Name:
conv_coder

Overview:
- Serial rate-1/2 feed-forward convolutional encoder. Default code: constraint length 3, generators (7,5) octal.
- Consumes one input bit every two clock cycles. Emits two coded bits on a single serial output: the G0 bit first, then the G1 bit.
- Sits between a serial bit source that holds each data bit for two clocks and a serial channel or modulator.

Parameters:
- K, 3, constraint length. Shift register holds K-1 past bits; K ≥ 2.
- G0, 3'b111, generator for first coded bit, K bits wide. MSB taps the current input; bit K-2 down to 0 tap delays 1..K-1 (bit 0 = oldest).
- G1, 3'b101, generator for second coded bit, same tap convention as G0.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- x  input  1  serial data bit; must be stable across the rising edge of each sampling cycle.
- y  output  1  registered serial coded bit.

Behaviour:
- Interface (already decided): one clock, clk. Reset port named reset; it is synchronous and active-low, sampled on the rising edge of clk.
- State:
  - sr[K-2:0]: past input bits, sr[K-2] newest.
  - phase: 1 bit.
  - g1_hold: 1 bit.
  - y register.
- Reset (reset==0 at a rising edge):
  - sr = 0, phase = 0, g1_hold = 0, y = 0.
  - Applies regardless of phase; a reset mid-pair discards the pending G1 bit.
- Phase 0 edge (reset==1, phase==0):
  - Sample u = x.
  - y <= XOR over taps of G0 applied to {u, sr}.
  - g1_hold <= XOR over taps of G1 applied to {u, sr}.
  - sr <= {u, sr[K-2:1]} (shift toward oldest).
  - phase <= 1.
- Phase 1 edge (reset==1, phase==1):
  - y <= g1_hold.
  - sr unchanged; x ignored.
  - phase <= 0.
- Timing:
  - Sampling edges: the first rising edge with reset high after release, then every second edge.
  - y shows G0(u) during the cycle after the sampling edge, then G1(u) during the cycle after that.
  - Latency: G0 bit valid 1 cycle after sampling; continuous throughput of one input bit per 2 clocks with no idle cycles.
- Default (7,5) code, with s1 = newest past bit and s2 = oldest:
  - G0 = u^s1^s2.
  - G1 = u^s2.
- No flushing logic. The encoder does not append tail zeros; the source supplies K-1 zero bits to terminate the trellis.
- x changes between sampling edges have no effect; only the value at a phase-0 edge matters.
- No combinational path from x to y.

Test Plan:
- Reset with reset=0 for ≥1 edge and x=X → y=0 and phase=0; after release, the first edge samples x.
- From reset, hold x = 1,0,0,1,1,0,0 for two clocks each (10 ns clock, x changes mid-cycle) → y sequence from the first post-reset edge = 1,1, 1,0, 1,1, 1,1, 0,1, 0,1, 1,1.
- All-zero input for 8 bits after reset → y constantly 0.
- Single 1 followed by zeros (1,0,0,0) → y = 11 10 11 00, the impulse response of (7,5).
- Assert reset=0 on the edge after a phase-0 sample of x=1 → y=0 next cycle (pending G1 discarded); resume with input 1 → y = 1,1 (state cleared).
- x glitching between sampling edges, e.g. a pulse during the phase-1 cycle → output identical to the glitch-free sequence.
